// File: rtl/muldiv_unit_if.sv
// ---------------------------------------------------------------------------
// muldiv_unit_if
// Request/response bundle for the iterative multiply/divide unit.
//   start    : request to begin an operation (master -> slave)
//   instr    : full 32-bit instruction; funct3 picks the M-extension op
//   rs1_val  : operand A (multiplicand / dividend)
//   rs2_val  : operand B (multiplier / divisor)
//   busy     : operation in flight, including the done cycle (slave -> master)
//   done     : one-cycle pulse, result valid
//   result   : registered result, held until the next operation completes
// ---------------------------------------------------------------------------
interface muldiv_unit_if;
    logic        start;
    logic [31:0] instr;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        busy;
    logic        done;
    logic [31:0] result;

    modport master (
        output start, instr, rs1_val, rs2_val,
        input  busy, done, result
    );

    modport slave (
        input  start, instr, rs1_val, rs2_val,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
// Iterative RISC-V M-extension unit: one result bit per cycle, 32 cycles
// per multiply or divide. Divide-by-zero and signed overflow are resolved
// immediately without iterating.
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset (wins over start)
//   bus  : muldiv_unit_if.slave (start/instr/rs1_val/rs2_val in,
//          busy/done/result out)
// ---------------------------------------------------------------------------
module muldiv_unit (
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [2:0]  op_q;
    logic [31:0] hi_q;       // product high half / partial remainder
    logic [31:0] lo_q;       // multiplier being consumed / dividend->quotient
    logic [31:0] opb_q;      // multiplicand (mul) or divisor (div), magnitude
    logic        neg_q;      // negate product / quotient at the end
    logic        rem_neg_q;  // negate remainder (dividend was negative)
    logic [31:0] result_q;

    // ---------------- request decode ----------------
    logic [2:0]  f3;
    logic        is_m_op;
    logic        req_div;
    logic        a_sgn, b_sgn;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic        div_zero, div_ovf;
    logic [31:0] special_res;

    assign f3      = bus.instr[14:12];
    assign is_m_op = (bus.instr[6:0] == 7'b0110011) && (bus.instr[31:25] == 7'b0000001);
    assign req_div = f3[2];

    always_comb begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        if (req_div) begin
            // DIV/REM signed, DIVU/REMU unsigned
            a_sgn = ~f3[0];
            b_sgn = ~f3[0];
        end else begin
            // MUL/MULH signed x signed, MULHSU signed x unsigned, MULHU unsigned
            a_sgn = (f3 != 3'b011);
            b_sgn = ~f3[1];
        end
    end

    assign a_neg = a_sgn & bus.rs1_val[31];
    assign b_neg = b_sgn & bus.rs2_val[31];
    assign a_mag = a_neg ? (~bus.rs1_val + 32'd1) : bus.rs1_val;
    assign b_mag = b_neg ? (~bus.rs2_val + 32'd1) : bus.rs2_val;

    assign div_zero = req_div && (bus.rs2_val == 32'd0);
    assign div_ovf  = req_div && !f3[0] && (bus.rs1_val == 32'h8000_0000)
                      && (bus.rs2_val == 32'hFFFF_FFFF);

    // f3[1] distinguishes REM/REMU from DIV/DIVU
    assign special_res = div_zero ? (f3[1] ? bus.rs1_val : 32'hFFFF_FFFF)
                                  : (f3[1] ? 32'h0000_0000 : 32'h8000_0000);

    // ---------------- one iteration step ----------------
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [32:0] div_trial;
    logic [31:0] hi_d, lo_d;
    logic [63:0] prod_s;
    logic [31:0] final_res;

    always_comb begin
        hi_d      = hi_q;
        lo_d      = lo_q;
        mul_sum   = 33'd0;
        div_shift = 33'd0;
        div_trial = 33'd0;
        prod_s    = 64'd0;
        final_res = 32'd0;

        if (op_q[2]) begin
            // restoring division: shift in next dividend bit, try subtracting
            div_shift = {hi_q, lo_q[31]};
            div_trial = div_shift - {1'b0, opb_q};
            if (!div_trial[32]) begin
                hi_d = div_trial[31:0];
                lo_d = {lo_q[30:0], 1'b1};
            end else begin
                hi_d = div_shift[31:0];
                lo_d = {lo_q[30:0], 1'b0};
            end
            if (op_q[1]) begin
                final_res = rem_neg_q ? (~hi_d + 32'd1) : hi_d;
            end else begin
                final_res = neg_q ? (~lo_d + 32'd1) : lo_d;
            end
        end else begin
            // shift-add with the product shifting right through {hi, lo}
            mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : 33'd0);
            hi_d    = mul_sum[32:1];
            lo_d    = {mul_sum[0], lo_q[31:1]};
            prod_s  = neg_q ? (~{hi_d, lo_d} + 64'd1) : {hi_d, lo_d};
            final_res = (op_q[1:0] == 2'b00) ? prod_s[31:0] : prod_s[63:32];
        end
    end

    // ---------------- FSM and datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 5'd0;
            op_q      <= 3'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            opb_q     <= 32'd0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            result_q  <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start && is_m_op) begin
                        op_q      <= f3;
                        neg_q     <= a_neg ^ b_neg;
                        rem_neg_q <= a_neg;
                        hi_q      <= 32'd0;
                        lo_q      <= req_div ? a_mag : b_mag;
                        opb_q     <= req_div ? b_mag : a_mag;
                        cnt_q     <= 5'd0;
                        if (div_zero || div_ovf) begin
                            result_q <= special_res;
                            state_q  <= DONE;
                        end else begin
                            state_q  <= CALC;
                        end
                    end
                end
                CALC: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        result_q <= final_res;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = (state_q == DONE);
    assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
// Directed vectors for muldiv_unit. Expected results are queued when an
// operation is issued; a monitor pops and compares on every done pulse.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;

    logic clk;
    logic rst;

    muldiv_unit_if bus ();

    muldiv_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];

    function automatic logic [31:0] m_instr(input logic [2:0] f3);
        return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end else begin
            $display("ok   %s value=%h", name, act);
        end
    endtask

    // Scoreboard monitor: compare result on each done pulse
    task automatic monitor();
        logic [31:0] e;
        string       n;
        forever begin
            @(negedge clk);
            if (!rst && bus.done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=%h required=no_done", bus.result);
                end else begin
                    e = exp_q.pop_front();
                    n = name_q.pop_front();
                    check({n, "_result"}, bus.result, e);
                end
            end
        end
    endtask

    // Issue one op, scramble inputs after acceptance, measure latency/busy,
    // optionally poke start mid-CALC, then try a start in the DONE cycle.
    task automatic run_op(input string name, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat, input bit poke);
        int cyc;
        int busy_cnt;
        bit seen;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.instr   = m_instr(f3);
        bus.rs1_val = a;
        bus.rs2_val = b;
        exp_q.push_back(exp);
        name_q.push_back(name);
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.instr   = m_instr(~f3);
        bus.rs1_val = ~a;
        bus.rs2_val = b + 32'd5;
        seen = 1'b0;
        busy_cnt = 0;
        cyc = 0;
        while (!seen && cyc < 60) begin
            cyc++;
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                seen = 1'b1;
            end else begin
                if (poke && cyc == 5) begin
                    bus.start   = 1'b1;
                    bus.instr   = m_instr(3'b101);
                    bus.rs2_val = 32'd0;
                end else begin
                    bus.start = 1'b0;
                end
                @(posedge clk);
                #1;
            end
        end
        check({name, "_done_seen"}, {31'd0, seen}, 32'd1);
        check({name, "_latency"}, cyc, exp_lat);
        check({name, "_busy_cycles"}, busy_cnt, exp_lat);
        // start during DONE must be ignored
        bus.start   = 1'b1;
        bus.instr   = m_instr(3'b000);
        bus.rs1_val = 32'd9;
        bus.rs2_val = 32'd9;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check({name, "_idle_after_done"}, {31'd0, bus.busy}, 32'd0);
        check({name, "_result_hold"}, bus.result, exp);
    endtask

    initial begin
        int dones;
        fork
            monitor();
        join_none

        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.instr   = 32'd0;
        bus.rs1_val = 32'd0;
        bus.rs2_val = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_busy",   {31'd0, bus.busy}, 32'd0);
        check("reset_done",   {31'd0, bus.done}, 32'd0);
        check("reset_result", bus.result, 32'd0);

        // first op issued in the first cycle after reset deasserts
        run_op("mul_7xm3",     3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 1'b0);
        run_op("mulhu_m1xm1",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b0);
        run_op("mulh_m1xm1",   3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, 1'b0);
        run_op("div_m7d2",     3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, 1'b0);
        run_op("rem_m7d2",     3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, 1'b0);
        run_op("divu_big_d2",  3'b101, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, 33, 1'b0);
        run_op("divu_5d0",     3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF, 1,  1'b0);
        run_op("remu_5d0",     3'b111, 32'd5,          32'd0,         32'd5,         1,  1'b0);
        run_op("div_ovf",      3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  1'b0);
        run_op("rem_ovf",      3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1,  1'b0);
        // MULHSU: -1 (signed) x 2 (unsigned) = -2 -> high word all ones; start poked mid-CALC
        run_op("mulhsu_poke",  3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33, 1'b1);
        run_op("remu_7d3",     3'b111, 32'd7,          32'd3,         32'd1,         33, 1'b0);

        // non-M instruction (ADD) must be ignored
        @(negedge clk);
        bus.start   = 1'b1;
        bus.instr   = 32'h0020_8033;
        bus.rs1_val = 32'd1;
        bus.rs2_val = 32'd2;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("nonm_ignored_busy", {31'd0, bus.busy}, 32'd0);
        @(posedge clk);
        #1;
        check("nonm_still_idle", {31'd0, bus.busy}, 32'd0);

        // reset at CALC cycle 10, with a competing start on the same edge
        @(negedge clk);
        bus.start   = 1'b1;
        bus.instr   = m_instr(3'b000);
        bus.rs1_val = 32'd100;
        bus.rs2_val = 32'd200;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        check("abort_busy_before_rst", {31'd0, bus.busy}, 32'd1);
        rst         = 1'b1;
        bus.start   = 1'b1;
        bus.instr   = m_instr(3'b101);
        bus.rs1_val = 32'd5;
        bus.rs2_val = 32'd0;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        bus.start = 1'b0;
        check("abort_busy",   {31'd0, bus.busy}, 32'd0);
        check("abort_done",   {31'd0, bus.done}, 32'd0);
        check("abort_result", bus.result, 32'd0);
        dones = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        check("abort_no_done", dones, 0);

        run_op("mul_3x4", 3'b000, 32'd3, 32'd4, 32'd12, 33, 1'b0);

        repeat (3) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
